// File: rtl/cv32e40p_pkg2_ft.sv
// Shared constants for the IF-stage fault-tolerance manager.
// Holds the sub-unit indices, the default breakage-monitor settings and the
// recovery FSM state type used by cv32e40p_if_stage_ft_manager.
package cv32e40p_pkg2_ft;

    // IF-stage sub-unit indices
    localparam int unsigned IFST_PC_I       = 0;
    localparam int unsigned IFST_PREFETCH_I = 1;
    localparam int unsigned IFST_FSM_I      = 2;
    localparam int unsigned IFST_PIPE_I     = 3;
    localparam int unsigned IFST_ALIGNER_I  = 4;
    localparam int unsigned IFST_CDEC_I     = 5;
    localparam int unsigned IFST_N_SUB      = 6;
    localparam int unsigned IFST_ID_W       = 3;

    // Per-unit breakage monitor defaults
    localparam int unsigned FT_COUNT_BIT          = 8;
    localparam int unsigned FT_INC_DEC_BIT        = 2;
    localparam int unsigned FT_INCREMENT          = 1;
    localparam int unsigned FT_DECREMENT          = 1;
    localparam int unsigned FT_BREAKING_THRESHOLD = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } ifst_ftm_state_e;

endpackage

// File: rtl/cv32e40p_ft_breakage_counter.sv
// One breakage monitor: saturating up/down counter plus a sticky broken flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      synchronous clear of count and broken flag (overrides err_i)
//   err_i        voter mismatch flag for this unit
//   cnt_o        current count
//   broken_o     sticky flag, set when the next count reaches the threshold
module cv32e40p_ft_breakage_counter
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned COUNT_BIT          = FT_COUNT_BIT,
    parameter int unsigned INC_DEC_BIT        = FT_INC_DEC_BIT,
    parameter int unsigned INCREMENT          = FT_INCREMENT,
    parameter int unsigned DECREMENT          = FT_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = FT_BREAKING_THRESHOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 err_i,
    output logic [COUNT_BIT-1:0] cnt_o,
    output logic                 broken_o
);

    localparam logic [INC_DEC_BIT-1:0] INC_STEP = INC_DEC_BIT'(INCREMENT);
    localparam logic [INC_DEC_BIT-1:0] DEC_STEP = INC_DEC_BIT'(DECREMENT);
    // Steps zero-extended into the COUNT_BIT+1 intermediate so the top bit
    // flags overflow (increment) or borrow (decrement).
    localparam logic [COUNT_BIT:0] INC_EXT = {{(COUNT_BIT + 1 - INC_DEC_BIT){1'b0}}, INC_STEP};
    localparam logic [COUNT_BIT:0] DEC_EXT = {{(COUNT_BIT + 1 - INC_DEC_BIT){1'b0}}, DEC_STEP};
    localparam logic [COUNT_BIT-1:0] THRESH = COUNT_BIT'(BREAKING_THRESHOLD);

    logic [COUNT_BIT-1:0] cnt_q, cnt_d;
    logic                 broken_q, broken_d;
    logic [COUNT_BIT:0]   sum, diff;

    always_comb begin
        sum  = {1'b0, cnt_q} + INC_EXT;
        diff = {1'b0, cnt_q} - DEC_EXT;
        if (clear_i) begin
            cnt_d    = '0;
            broken_d = 1'b0;
        end else begin
            if (err_i) begin
                cnt_d = sum[COUNT_BIT] ? '1 : sum[COUNT_BIT-1:0];
            end else begin
                cnt_d = diff[COUNT_BIT] ? '0 : diff[COUNT_BIT-1:0];
            end
            broken_d = broken_q | (cnt_d >= THRESH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            broken_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            broken_q <= broken_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign broken_o = broken_q;

endmodule

// File: rtl/cv32e40p_if_stage_ft_manager.sv
// Fault-tolerance manager for the six IF-stage sub-units.
// One breakage monitor per unit plus a round-robin arbiter that offers units with
// pending errors (and not broken) to the controller over a req/gnt/done handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   err_i[N_SUB]          per-unit voter mismatch flags
//   clear_i               clears counters, broken, pending, rr pointer and the FSM
//   rec_req_o, rec_id_o   recovery request and unit index (held while requesting)
//   rec_gnt_i, rec_done_i controller accept / recovery finished
//   broken_o, fatal_o     sticky per-unit broken flags and their OR
//   cnt_o                 packed counters, unit k at [k*COUNT_BIT +: COUNT_BIT]
module cv32e40p_if_stage_ft_manager
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned N_SUB              = IFST_N_SUB,
    parameter int unsigned ID_W               = IFST_ID_W,
    parameter int unsigned COUNT_BIT          = FT_COUNT_BIT,
    parameter int unsigned INC_DEC_BIT        = FT_INC_DEC_BIT,
    parameter int unsigned INCREMENT          = FT_INCREMENT,
    parameter int unsigned DECREMENT          = FT_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = FT_BREAKING_THRESHOLD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SUB-1:0]           err_i,
    input  logic                       clear_i,
    output logic                       rec_req_o,
    output logic [ID_W-1:0]            rec_id_o,
    input  logic                       rec_gnt_i,
    input  logic                       rec_done_i,
    output logic [N_SUB-1:0]           broken_o,
    output logic                       fatal_o,
    output logic [N_SUB*COUNT_BIT-1:0] cnt_o
);

    ifst_ftm_state_e  state_q, state_d;
    logic             rec_req_q, rec_req_d;
    logic [ID_W-1:0]  rec_id_q, rec_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_SUB-1:0] pending_q, pending_d;
    logic [N_SUB-1:0] eligible, done_mask;
    logic [ID_W-1:0]  pick_id, idx_id;
    logic             found;

    for (genvar k = 0; k < N_SUB; k++) begin : g_mon
        cv32e40p_ft_breakage_counter #(
            .COUNT_BIT          (COUNT_BIT),
            .INC_DEC_BIT        (INC_DEC_BIT),
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (clear_i),
            .err_i    (err_i[k]),
            .cnt_o    (cnt_o[k*COUNT_BIT +: COUNT_BIT]),
            .broken_o (broken_o[k])
        );
    end

    assign fatal_o  = |broken_o;
    assign eligible = pending_q & ~broken_o;

    // First eligible unit at or after rr_ptr, wrapping modulo N_SUB.
    always_comb begin
        found   = 1'b0;
        pick_id = '0;
        idx_id  = '0;
        for (int unsigned i = 0; i < N_SUB; i++) begin
            idx_id = ID_W'((32'(rr_ptr_q) + i) % N_SUB);
            if (!found && eligible[idx_id]) begin
                found   = 1'b1;
                pick_id = idx_id;
            end
        end
    end

    always_comb begin
        done_mask = '0;
        if (state_q == BUSY && rec_done_i) begin
            done_mask[rec_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_req_d = rec_req_q;
        rec_id_d  = rec_id_q;
        rr_ptr_d  = rr_ptr_q;
        // A new error in the completion cycle keeps the unit pending.
        pending_d = (pending_q & ~done_mask) | err_i;
        case (state_q)
            IDLE: begin
                if (found) begin
                    rec_id_d  = pick_id;
                    rec_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (rec_gnt_i) begin
                    rec_req_d = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (rec_done_i) begin
                    rr_ptr_d = (rec_id_q == ID_W'(N_SUB - 1)) ? '0 : rec_id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                rec_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        if (clear_i) begin
            state_d   = IDLE;
            rec_req_d = 1'b0;
            rec_id_d  = '0;
            rr_ptr_d  = '0;
            pending_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rec_req_q <= 1'b0;
            rec_id_q  <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            rec_req_q <= rec_req_d;
            rec_id_q  <= rec_id_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

    assign rec_req_o = rec_req_q;
    assign rec_id_o  = rec_id_q;

endmodule

// File: tb/tb_cv32e40p_if_stage_ft_manager.sv
module tb_cv32e40p_if_stage_ft_manager;
    import cv32e40p_pkg2_ft::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  err_i;
    logic        clear_i;
    logic        rec_req_o;
    logic [2:0]  rec_id_o;
    logic        rec_gnt_i;
    logic        rec_done_i;
    logic [5:0]  broken_o;
    logic        fatal_o;
    logic [47:0] cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_id_q[$];

    cv32e40p_if_stage_ft_manager dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .err_i      (err_i),
        .clear_i    (clear_i),
        .rec_req_o  (rec_req_o),
        .rec_id_o   (rec_id_o),
        .rec_gnt_i  (rec_gnt_i),
        .rec_done_i (rec_done_i),
        .broken_o   (broken_o),
        .fatal_o    (fatal_o),
        .cnt_o      (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt_of(input int k);
        return cnt_o[k*8 +: 8];
    endfunction

    task automatic do_reset();
        err_i      = '0;
        clear_i    = 1'b0;
        rec_gnt_i  = 1'b0;
        rec_done_i = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait for a request, check its id against the scoreboard, then gnt and done.
    task automatic serve(input string tag);
        bit seen = 1'b0;
        int exp;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rec_req_o === 1'b1) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s req_timeout: rec_req_o=%0b required 1", tag, rec_req_o);
            return;
        end
        n_cmp++;
        if (exp_id_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_req: rec_id_o=%0d, no request expected", tag, rec_id_o);
            exp = -1;
        end else begin
            exp = exp_id_q.pop_front();
            if (rec_id_o !== 3'(exp)) begin
                n_fail++;
                $display("FAIL %s req_id: rec_id_o=%0d required %0d", tag, rec_id_o, exp);
            end
        end
        rec_gnt_i = 1'b1;
        tick();
        rec_gnt_i = 1'b0;
        n_cmp++;
        if (rec_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s req_drop: rec_req_o=%0b required 0", tag, rec_req_o);
        end
        rec_done_i = 1'b1;
        tick();
        rec_done_i = 1'b0;
    endtask

    task automatic test_reset();
        err_i = '0; clear_i = 0; rec_gnt_i = 0; rec_done_i = 0; rst_n = 0;
        #2;
        n_cmp++;
        if (rec_req_o !== 1'b0 || rec_id_o !== 3'd0 || fatal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%0b id=%0d fatal=%0b required 0 0 0",
                     rec_req_o, rec_id_o, fatal_o);
        end
        n_cmp++;
        if (broken_o !== 6'd0 || cnt_o !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_state: broken=%b cnt=%h required 0 0", broken_o, cnt_o);
        end
        do_reset();
    endtask

    task automatic test_broken();
        logic [7:0] exp_cnt [3] = '{8'd1, 8'd2, 8'd3};
        bit any_req = 1'b0;
        do_reset();
        err_i = 6'b000100;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (cnt_of(2) !== exp_cnt[c]) begin
                n_fail++;
                $display("FAIL broken_cnt%0d: cnt2=%0d required %0d", c, cnt_of(2), exp_cnt[c]);
            end
            n_cmp++;
            if (broken_o !== ((c == 2) ? 6'b000100 : 6'b000000)) begin
                n_fail++;
                $display("FAIL broken_flag%0d: broken=%b", c, broken_o);
            end
        end
        err_i = '0;
        n_cmp++;
        if (fatal_o !== 1'b1) begin
            n_fail++;
            $display("FAIL broken_fatal: fatal=%0b required 1", fatal_o);
        end
        // Request launched before the unit broke is not aborted.
        exp_id_q.push_back(2);
        serve("broken_inflight");
        err_i = 6'b000100;
        tick();
        err_i = '0;
        for (int c = 0; c < 10; c++) begin
            if (rec_req_o !== 1'b0) any_req = 1'b1;
            tick();
        end
        n_cmp++;
        if (any_req) begin
            n_fail++;
            $display("FAIL broken_no_req: broken unit 2 requested, required no request");
        end
        n_cmp++;
        if (broken_o !== 6'b000100) begin
            n_fail++;
            $display("FAIL broken_sticky: broken=%b required 000100", broken_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        err_i = 6'b010000;
        tick();
        err_i = '0;
        n_cmp++;
        if (rec_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: rec_req_o=%0b required 0", rec_req_o);
        end
        tick();
        n_cmp++;
        if (rec_req_o !== 1'b1 || rec_id_o !== 3'd4) begin
            n_fail++;
            $display("FAIL single_req: req=%0b id=%0d required 1 4", rec_req_o, rec_id_o);
        end
        rec_gnt_i = 1'b1;
        tick();
        rec_gnt_i = 1'b0;
        n_cmp++;
        if (dut.state_q !== BUSY || rec_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: state=%0d req=%0b required 2 0", dut.state_q, rec_req_o);
        end
        rec_done_i = 1'b1;
        tick();
        rec_done_i = 1'b0;
        n_cmp++;
        if (dut.pending_q !== 6'd0 || dut.rr_ptr_q !== 3'd5 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL single_done: pending=%b rr=%0d state=%0d required 0 5 0",
                     dut.pending_q, dut.rr_ptr_q, dut.state_q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        err_i = 6'b100011;
        exp_id_q.push_back(0);
        exp_id_q.push_back(1);
        exp_id_q.push_back(5);
        tick();
        err_i = '0;
        serve("rr_a0");
        serve("rr_a1");
        serve("rr_a5");
        // Bring rr_ptr to 2, then pending {0,3}: 3 must go before 0.
        do_reset();
        err_i = 6'b000010;
        exp_id_q.push_back(1);
        tick();
        err_i = '0;
        serve("rr_b1");
        err_i = 6'b001001;
        exp_id_q.push_back(3);
        exp_id_q.push_back(0);
        tick();
        err_i = '0;
        serve("rr_b3");
        serve("rr_b0");
    endtask

    task automatic test_saturation();
        do_reset();
        err_i = 6'b000010;
        for (int c = 0; c < 300; c++) tick();
        n_cmp++;
        if (cnt_of(1) !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_high: cnt1=%0d required 255", cnt_of(1));
        end
        err_i = '0;
        for (int c = 0; c < 300; c++) tick();
        n_cmp++;
        if (cnt_of(1) !== 8'd0 || broken_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_low: cnt1=%0d broken1=%0b required 0 1", cnt_of(1), broken_o[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        err_i = 6'b000001;
        tick(); tick(); tick();
        err_i = '0;
        n_cmp++;
        if (rec_req_o !== 1'b1 || broken_o !== 6'b000001) begin
            n_fail++;
            $display("FAIL areset_pre: req=%0b broken=%b required 1 000001", rec_req_o, broken_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rec_req_o !== 1'b0 || broken_o !== 6'd0 || cnt_o !== 48'd0 || fatal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: req=%0b broken=%b cnt=%h fatal=%0b required all 0",
                     rec_req_o, broken_o, cnt_o, fatal_o);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_clear();
        bit any_req = 1'b0;
        do_reset();
        err_i = 6'b000100;
        tick();
        err_i = '0;
        tick();
        rec_gnt_i = 1'b1;
        tick();
        rec_gnt_i = 1'b0;
        clear_i = 1'b1;
        err_i   = 6'b001000;
        tick();
        clear_i = 1'b0;
        err_i   = '0;
        n_cmp++;
        if (dut.state_q !== IDLE || cnt_o !== 48'd0 || dut.pending_q !== 6'd0) begin
            n_fail++;
            $display("FAIL clear_state: state=%0d cnt=%h pending=%b required 0 0 0",
                     dut.state_q, cnt_o, dut.pending_q);
        end
        rec_done_i = 1'b1;
        tick();
        rec_done_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rec_req_o !== 1'b0) any_req = 1'b1;
            tick();
        end
        n_cmp++;
        if (dut.rr_ptr_q !== 3'd0 || any_req) begin
            n_fail++;
            $display("FAIL clear_done_ignored: rr=%0d req_seen=%0b required 0 0",
                     dut.rr_ptr_q, any_req);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        err_i = 6'b001000;
        tick();
        err_i = '0;
        tick();
        n_cmp++;
        if (rec_req_o !== 1'b1 || rec_id_o !== 3'd3) begin
            n_fail++;
            $display("FAIL setwin_req: req=%0b id=%0d required 1 3", rec_req_o, rec_id_o);
        end
        rec_gnt_i = 1'b1;
        tick();
        rec_gnt_i  = 1'b0;
        rec_done_i = 1'b1;
        err_i      = 6'b001000;
        tick();
        rec_done_i = 1'b0;
        err_i      = '0;
        n_cmp++;
        if (dut.pending_q[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL setwin_pending: pending3=%0b required 1", dut.pending_q[3]);
        end
        exp_id_q.push_back(3);
        serve("setwin_again");
    endtask

    initial begin
        test_reset();
        test_broken();
        test_single();
        test_round_robin();
        test_saturation();
        test_async_reset();
        test_clear();
        test_set_wins();
        n_cmp++;
        if (exp_id_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected requests left, required 0",
                     exp_id_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
